// File: rtl/flit_sequencer.sv
// Per-VC flit framing checker with a one-entry valid/ready output stage.
// Optional FLIT_SEQ_DROP_ON_ERROR_EN: errored flits are counted but not forwarded.
module flit_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int PhitPerFlit   = 2,
  parameter int TYPE_WIDTH    = 2,
  parameter int NUM_VC        = 4,
  parameter int MAX_PAYLOAD   = 8,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int FLIT_WIDTH   = DATA_WIDTH * PhitPerFlit,
  localparam int VC_WIDTH     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_WIDTH    = $clog2(MAX_PAYLOAD + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  input  logic [VC_WIDTH-1:0]      in_vc,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  output logic [VC_WIDTH-1:0]      out_vc,
  output logic [TYPE_WIDTH-1:0]    out_type,
  output logic [2:0]               out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  localparam logic [TYPE_WIDTH-1:0] T_DEFAULT = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] T_HEAD    = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_PAYLOAD = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL    = TYPE_WIDTH'(3);

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ORPH_PAY = 3'd1;
  localparam logic [2:0] E_ORPH_TL  = 3'd2;
  localparam logic [2:0] E_RESTART  = 3'd3;
  localparam logic [2:0] E_DEFAULT  = 3'd4;
  localparam logic [2:0] E_OVERFLOW = 3'd5;
  localparam logic [2:0] E_BAD_VC   = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PAYLOAD);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  logic [0:0]               r_state [NUM_VC];
  logic [CNT_WIDTH-1:0]     r_cnt   [NUM_VC];
  logic [FLIT_WIDTH-1:0]    r_flit_p1;
  logic [VC_WIDTH-1:0]      r_vc_p1;
  logic [TYPE_WIDTH-1:0]    r_type_p1;
  logic [2:0]               r_err_p1;
  logic                     r_vld_p1;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [TYPE_WIDTH-1:0]    w_tid;
  logic [TYPE_WIDTH-1:0]    w_type;
  logic [31:0]              w_vc_ext;
  logic                     w_vc_ok;
  logic                     w_in_ready;
  logic                     w_acc;
  logic                     w_load;
  logic [0:0]               w_cur_state;
  logic [CNT_WIDTH-1:0]     w_cur_cnt;
  logic [0:0]               w_nxt_state;
  logic [CNT_WIDTH-1:0]     w_nxt_cnt;
  logic [2:0]               w_err;

  // Stage p0: decode and framing decision against the addressed VC
  assign w_tid    = in_flit[FLIT_WIDTH-1 -: TYPE_WIDTH];
  assign w_type   = (w_tid == T_HEAD || w_tid == T_PAYLOAD || w_tid == T_TAIL) ? w_tid : T_DEFAULT;
  assign w_vc_ext = 32'(in_vc);
  assign w_vc_ok  = (w_vc_ext < 32'(NUM_VC));

  assign w_in_ready = ~r_vld_p1 | out_ready;
  assign w_acc      = in_valid & w_in_ready;

  assign w_cur_state = w_vc_ok ? r_state[in_vc] : S_IDLE;
  assign w_cur_cnt   = w_vc_ok ? r_cnt[in_vc] : '0;

  always_comb begin
    w_nxt_state = w_cur_state;
    w_nxt_cnt   = w_cur_cnt;
    w_err       = E_NONE;
    if (!w_vc_ok) begin
      w_err = E_BAD_VC;
    end else begin
      case (w_type)
        T_HEAD: begin
          w_err       = (w_cur_state == S_IN_PKT) ? E_RESTART : E_NONE;
          w_nxt_state = S_IN_PKT;
          w_nxt_cnt   = '0;
        end
        T_PAYLOAD: begin
          if (w_cur_state == S_IDLE)  w_err = E_ORPH_PAY;
          else if (w_cur_cnt == CNT_MAX) w_err = E_OVERFLOW;
          else w_nxt_cnt = w_cur_cnt + CNT_WIDTH'(1);
        end
        T_TAIL: begin
          if (w_cur_state == S_IDLE) begin
            w_err = E_ORPH_TL;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
          end
        end
        default: w_err = E_DEFAULT;
      endcase
    end
  end

`ifdef FLIT_SEQ_DROP_ON_ERROR_EN
  assign w_load = w_acc & (w_err == E_NONE);
`else
  assign w_load = w_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else if (w_acc && w_vc_ok) begin
      r_state[in_vc] <= w_nxt_state;
      r_cnt[in_vc]   <= w_nxt_cnt;
    end
  end

  // Stage p1: output holding register and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_flit_p1 <= '0;
      r_vc_p1   <= '0;
      r_type_p1 <= '0;
      r_err_p1  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_load) begin
        r_flit_p1 <= in_flit;
        r_vc_p1   <= in_vc;
        r_type_p1 <= w_type;
        r_err_p1  <= w_err;
      end
      r_vld_p1 <= w_load | (r_vld_p1 & ~out_ready);
      if (w_acc && w_err != E_NONE) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_flit  = r_flit_p1;
  assign out_vc    = r_vc_p1;
  assign out_type  = r_type_p1;
  assign out_err   = r_err_p1;
  assign out_valid = r_vld_p1;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_flit_sequencer.sv
// Bench for flit_sequencer: directed framing scenarios then random traffic against a packet-level model.
module tb_flit_sequencer;
  localparam int DW   = 32;
  localparam int PPF  = 2;
  localparam int FW   = DW * PPF;
  localparam int TW   = 2;
  localparam int NV   = 3;
  localparam int VCW  = 2;
  localparam int MAXP = 8;
  localparam int ECW  = 4;
  localparam int ECMAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [FW-1:0]  in_flit = '0;
  logic [VCW-1:0] in_vc = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [FW-1:0]  out_flit;
  logic [VCW-1:0] out_vc;
  logic [TW-1:0]  out_type;
  logic [2:0]     out_err;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [ECW-1:0] err_count;

  flit_sequencer #(
    .DATA_WIDTH(DW), .PhitPerFlit(PPF), .TYPE_WIDTH(TW), .NUM_VC(NV),
    .MAX_PAYLOAD(MAXP), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_vc(out_vc), .out_type(out_type),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Packet-level model: is a packet open on each VC, and how many payloads it has seen
  bit          m_open [NV];
  int          m_pay  [NV];
  bit          m_vld;
  logic [FW-1:0] m_flit;
  int          m_vc, m_type, m_err;
  int          m_ecnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_open[i] = 1'b0;
      m_pay[i]  = 0;
    end
    m_vld = 1'b0; m_flit = '0; m_vc = 0; m_type = 0; m_err = 0; m_ecnt = 0;
  endtask

  function automatic int judge(input int t, input int vc);
    int e;
    if (vc >= NV) return 6;
    case (t)
      1: begin
        e = m_open[vc] ? 3 : 0;
        m_open[vc] = 1'b1;
        m_pay[vc]  = 0;
      end
      2: begin
        if (!m_open[vc]) e = 1;
        else if (m_pay[vc] == MAXP) e = 5;
        else begin e = 0; m_pay[vc]++; end
      end
      3: begin
        if (!m_open[vc]) e = 2;
        else begin e = 0; m_open[vc] = 1'b0; m_pay[vc] = 0; end
      end
      default: e = 4;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_vc", out_vc, 0);
    chk("rst_out_type", out_type, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs after the edge
  task automatic cyc(input bit v, input int t, input int vc, input bit ordy);
    logic [FW-1:0] f;
    bit acc, load;
    int e;
    f = {$urandom, $urandom};
    f[FW-1 -: TW] = TW'(t);
    @(negedge clk);
    in_valid = v; in_flit = f; in_vc = VCW'(vc); out_ready = ordy;
    #1;
    chk("in_ready", in_ready, (!m_vld || ordy));
    acc = v && (!m_vld || ordy);
    e = 0;
    if (acc) e = judge(t, vc);
    load = acc;
`ifdef FLIT_SEQ_DROP_ON_ERROR_EN
    load = acc && (e == 0);
`endif
    if (load) begin
      m_vld = 1'b1; m_flit = f; m_vc = vc; m_type = t; m_err = e;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    if (acc && e != 0 && m_ecnt < ECMAX) m_ecnt++;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_vld);
    chk("out_flit", out_flit, m_flit);
    chk("out_vc", out_vc, m_vc);
    chk("out_type", out_type, m_type);
    chk("out_err", out_err, m_err);
    chk("err_count", err_count, m_ecnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Clean packet on VC0
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1);
    chk("clean_type_tail", out_type, 3);
    chk("clean_err_count", err_count, 0);

    // Orphans on VC0, then a HEAD proves it stayed idle
    cyc(1, 2, 0, 1);
`ifndef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("orphan_pay_err", out_err, 1);
`endif
    cyc(1, 3, 0, 1);
`ifndef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("orphan_tail_err", out_err, 2);
`endif
    chk("orphan_err_count", err_count, 2);
    cyc(1, 1, 0, 1);
    chk("idle_head_err", out_err, 0);
    cyc(1, 3, 0, 1);

    // Interleaved VCs
    cyc(1, 1, 1, 1); cyc(1, 1, 2, 1); cyc(1, 3, 1, 1); cyc(1, 2, 2, 1); cyc(1, 3, 2, 1);
    chk("interleave_err", out_err, 0);

    // Payload overflow
    cyc(1, 1, 0, 1);
    for (int i = 0; i < MAXP + 1; i++) cyc(1, 2, 0, 1);
`ifndef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("overflow_err", out_err, 5);
`endif
    chk("overflow_err_count", err_count, 3);
    cyc(1, 3, 0, 1);
    chk("overflow_tail_err", out_err, 0);

    // Backpressure: held output, then restart HEAD mid-packet
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 2, 1, 0);
    chk("stall_vc", out_vc, 1);
    chk("stall_type", out_type, 1);
    cyc(1, 2, 1, 1);
    chk("release_type", out_type, 2);
    cyc(1, 1, 1, 1);
`ifndef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("restart_err", out_err, 3);
`endif
    cyc(1, 3, 1, 1);

    // DEFAULT between valid flits, and an out-of-range VC
    cyc(1, 1, 2, 1); cyc(1, 0, 2, 1);
`ifdef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("drop_default_type", out_type, 1);
`else
    chk("default_err", out_err, 4);
`endif
    cyc(1, 3, 2, 1);
    cyc(1, 1, 3, 1);
`ifndef FLIT_SEQ_DROP_ON_ERROR_EN
    chk("bad_vc_err", out_err, 6);
`endif
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);

    // Counter saturation
    for (int i = 0; i < ECMAX + 4; i++) cyc(1, 0, 0, 1);
    chk("err_count_sat", err_count, ECMAX);

    // Reset mid-packet: next PAYLOAD on that VC is an orphan
    do_reset();
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 0);
    do_reset();
    cyc(1, 2, 0, 1);
    chk("post_reset_orphan_cnt", err_count, 1);

    // Random traffic, with occasional resets so the counter is exercised below saturation
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
